// File: rtl/delivery_map_scheduler.sv
// Paces map-advance pulses: samples the speed, then emits a fixed-length pulse train at that rate.
// Optional WAIT_VEL timeout and sticky sensor_fault are built with DELIVERY_MAP_SCHEDULER_TIMEOUT_EN.
module delivery_map_scheduler #(
  parameter int TICK_BASE        = 16,
  parameter int STEPS_PER_SAMPLE = 4,
  parameter int MEAS_TIMEOUT     = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       velocity_ready,
  input  logic [1:0] velocity,
  output logic       get_velocity,
  output logic       count_map,
  output logic [1:0] level,
  output logic       sensor_fault,
  output logic       busy,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQUEST  = 3'd1,
    WAIT_VEL = 3'd2,
    RUN      = 3'd3,
    STEP     = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] tick_cnt;
  logic [7:0] step_cnt;
  logic [7:0] tick_last;

  // RUN lasts P-1 cycles and STEP one more, so pulses land exactly P cycles apart.
  assign tick_last = 8'((TICK_BASE >> level) - 2);

  assign busy   = (state != IDLE);
  assign estado = state;

`ifdef DELIVERY_MAP_SCHEDULER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        fault;
  assign sensor_fault = fault;
`else
  assign sensor_fault = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= 8'd0;
      step_cnt     <= 8'd0;
      level        <= 2'd0;
      get_velocity <= 1'b0;
      count_map    <= 1'b0;
`ifdef DELIVERY_MAP_SCHEDULER_TIMEOUT_EN
      tmo_cnt      <= 16'd0;
      fault        <= 1'b0;
`endif
    end else begin
      get_velocity <= 1'b0;
      count_map    <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        tick_cnt <= 8'd0;
        step_cnt <= 8'd0;
`ifdef DELIVERY_MAP_SCHEDULER_TIMEOUT_EN
        tmo_cnt  <= 16'd0;
`endif
      end else begin
        case (state)
          IDLE: begin
            tick_cnt     <= 8'd0;
            step_cnt     <= 8'd0;
            state        <= REQUEST;
            get_velocity <= 1'b1;
          end
          REQUEST: begin
`ifdef DELIVERY_MAP_SCHEDULER_TIMEOUT_EN
            tmo_cnt <= 16'd0;
`endif
            state <= WAIT_VEL;
          end
          WAIT_VEL: begin
            // A ready on the final timeout cycle takes priority over the timeout.
            if (velocity_ready) begin
              level    <= velocity;
              tick_cnt <= 8'd0;
              state    <= RUN;
            end
`ifdef DELIVERY_MAP_SCHEDULER_TIMEOUT_EN
            else if (tmo_cnt == 16'(MEAS_TIMEOUT - 1)) begin
              fault    <= 1'b1;
              tmo_cnt  <= 16'd0;
              tick_cnt <= 8'd0;
              state    <= RUN;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
`endif
          end
          RUN: begin
            if (tick_cnt == tick_last) begin
              tick_cnt  <= 8'd0;
              state     <= STEP;
              count_map <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
          STEP: begin
            if (step_cnt == 8'(STEPS_PER_SAMPLE - 1)) begin
              step_cnt     <= 8'd0;
              state        <= REQUEST;
              get_velocity <= 1'b1;
            end else begin
              step_cnt <= step_cnt + 8'd1;
              state    <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
